// File: rtl/wb_pkg.sv
// Shared types for the register writeback path: source ids and the buffered entry.
package wb_pkg;

  localparam int WB_REG_W  = 32;
  localparam int WB_ADDR_W = 4;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_REG_W-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small in-order FIFO holding pending writebacks for one producer.
// The head is visible combinationally; push and pop may share an edge.
module wb_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_pop,
  input  T     i_din,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T               r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  logic w_push;
  logic w_pop;

  // Qualify requests against occupancy so the FIFO never over/underflows.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  // Entry storage; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end

  // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin writeback arbiter in front of the register file's single write port.
// ALU and load results are buffered per source; at most one write issues per cycle.
module reg_wb_arbiter
  import wb_pkg::*;
#(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [ADDR_WIDTH-1:0] i_alu_addr,
  input  logic [REG_WIDTH-1:0]  i_alu_data,
  input  logic                  i_ld_valid,
  output logic                  o_ld_ready,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [REG_WIDTH-1:0]  i_ld_data,
  output logic [ADDR_WIDTH-1:0] o_reg_addr_w,
  output logic [REG_WIDTH-1:0]  o_reg_val_w,
  output logic                  o_write_en
);

  wb_entry_t w_alu_in, w_ld_in, w_alu_head, w_ld_head;
  logic      w_alu_full, w_alu_empty, w_ld_full, w_ld_empty;
  logic      w_alu_push, w_ld_push;
  logic      w_gnt_alu, w_gnt_ld;
  wb_src_e   r_last_grant;

  assign w_alu_in = '{addr: i_alu_addr, data: i_alu_data};
  assign w_ld_in  = '{addr: i_ld_addr,  data: i_ld_data};

  // Ready looks only at registered occupancy, so there is no valid->ready path.
  assign o_alu_ready = !w_alu_full && !i_rst;
  assign o_ld_ready  = !w_ld_full  && !i_rst;
  assign w_alu_push  = i_alu_valid && o_alu_ready;
  assign w_ld_push   = i_ld_valid  && o_ld_ready;

  wb_fifo #(.T(wb_entry_t), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_alu_push),
    .i_pop  (w_gnt_alu),
    .i_din  (w_alu_in),
    .o_head (w_alu_head),
    .o_full (w_alu_full),
    .o_empty(w_alu_empty)
  );

  wb_fifo #(.T(wb_entry_t), .DEPTH(FIFO_DEPTH)) u_ld_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_ld_push),
    .i_pop  (w_gnt_ld),
    .i_din  (w_ld_in),
    .o_head (w_ld_head),
    .o_full (w_ld_full),
    .o_empty(w_ld_empty)
  );

  // Grant: a lone non-empty source wins; on a tie the source not granted last wins.
  // Nothing is granted while reset is held, so no write leaks out during reset.
  always_comb begin
    w_gnt_alu = 1'b0;
    w_gnt_ld  = 1'b0;
    if (!i_rst) begin
      if (!w_ld_empty && (w_alu_empty || r_last_grant == SRC_ALU)) w_gnt_ld  = 1'b1;
      else if (!w_alu_empty)                                       w_gnt_alu = 1'b1;
    end
  end

  // Remember the last winner; held when nothing is granted. Reset favours LOAD next.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_last_grant <= SRC_ALU;
    else if (w_gnt_ld)  r_last_grant <= SRC_LOAD;
    else if (w_gnt_alu) r_last_grant <= SRC_ALU;
  end

  // Drive the write port from the granted head; zeros when idle.
  always_comb begin
    o_write_en   = 1'b0;
    o_reg_addr_w = '0;
    o_reg_val_w  = '0;
    if (w_gnt_ld) begin
      o_write_en   = 1'b1;
      o_reg_addr_w = w_ld_head.addr;
      o_reg_val_w  = w_ld_head.data;
    end else if (w_gnt_alu) begin
      o_write_en   = 1'b1;
      o_reg_addr_w = w_alu_head.addr;
      o_reg_val_w  = w_alu_head.data;
    end
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: inputs driven and outputs sampled at negedge.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid;
  logic        alu_ready, ld_ready;
  logic [3:0]  alu_addr, ld_addr, wr_addr;
  logic [31:0] alu_data, ld_data, wr_data;
  logic        wr_en;

  int total = 0;
  int bad   = 0;

  logic [3:0]  rec_addr [0:31];
  logic [31:0] rec_data [0:31];
  int          rec_n;

  always #5 clk = ~clk;

  reg_wb_arbiter #(.REG_WIDTH(32), .ADDR_WIDTH(4), .FIFO_DEPTH(2)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_alu_valid (alu_valid),
    .o_alu_ready (alu_ready),
    .i_alu_addr  (alu_addr),
    .i_alu_data  (alu_data),
    .i_ld_valid  (ld_valid),
    .o_ld_ready  (ld_ready),
    .i_ld_addr   (ld_addr),
    .i_ld_data   (ld_data),
    .o_reg_addr_w(wr_addr),
    .o_reg_val_w (wr_data),
    .o_write_en  (wr_en)
  );

  // Streams n_alu ALU entries (r4+i, 0xA0+i) and n_ld load entries (r8+i, 0xB0+i)
  // with valid/ready handshakes, recording every issued write.
  task automatic run_stream(input int n_alu, input int n_ld,
                            output bit saw_alu_full, output bit saw_ld_full,
                            output bit timed_out);
    int ai = 0, li = 0, cyc = 0;
    bit af = 0, lf = 0;
    saw_alu_full = 0; saw_ld_full = 0; rec_n = 0;
    while (rec_n < n_alu + n_ld && cyc < 60) begin
      @(negedge clk); cyc++;
      if (wr_en) begin
        rec_addr[rec_n] = wr_addr; rec_data[rec_n] = wr_data; rec_n++;
      end
      if (af) ai++;
      if (lf) li++;
      if (!alu_ready) saw_alu_full = 1;
      if (!ld_ready)  saw_ld_full  = 1;
      alu_valid = (ai < n_alu); alu_addr = 4'(4 + ai); alu_data = 32'(32'hA0 + ai);
      ld_valid  = (li < n_ld);  ld_addr  = 4'(8 + li); ld_data  = 32'(32'hB0 + li);
      af = alu_valid && alu_ready;
      lf = ld_valid  && ld_ready;
    end
    alu_valid = 0; ld_valid = 0;
    timed_out = (rec_n < n_alu + n_ld);
  endtask

  task automatic test_reset();
    rst = 1; alu_valid = 0; ld_valid = 0;
    alu_addr = 0; alu_data = 0; ld_addr = 0; ld_data = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", wr_en); end
      total++; if (wr_addr !== 4'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", wr_addr); end
      total++; if (wr_data !== 32'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", wr_data); end
      total++; if ({alu_ready, ld_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {alu_ready, ld_ready}); end
    end
    rst = 0;
    @(negedge clk);
    total++; if ({alu_ready, ld_ready} !== 2'b11) begin bad++; $display("FAIL post_reset_ready got=%b exp=11", {alu_ready, ld_ready}); end
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL idle_we got=%b exp=0", wr_en); end
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL idle_we2 got=%b exp=0", wr_en); end
  endtask

  task automatic test_single_alu();
    alu_valid = 1; alu_addr = 4'd3; alu_data = 32'hDEADBEEF;
    @(negedge clk);
    alu_valid = 0;
    total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", wr_en); end
    total++; if (wr_addr !== 4'd3) begin bad++; $display("FAIL single_addr got=%0d exp=3", wr_addr); end
    total++; if (wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_data got=%h exp=deadbeef", wr_data); end
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL single_after_we got=%b exp=0", wr_en); end
  endtask

  task automatic test_tie();
    alu_valid = 1; alu_addr = 4'd1; alu_data = 32'h11;
    ld_valid  = 1; ld_addr  = 4'd2; ld_data  = 32'h22;
    @(negedge clk);
    alu_valid = 0; ld_valid = 0;
    total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd2, 32'h22}) begin
      bad++; $display("FAIL tie_first got=%b/%0d/%h exp=1/2/22", wr_en, wr_addr, wr_data); end
    @(negedge clk);
    total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd1, 32'h11}) begin
      bad++; $display("FAIL tie_second got=%b/%0d/%h exp=1/1/11", wr_en, wr_addr, wr_data); end
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL tie_idle got=%b exp=0", wr_en); end
  endtask

  task automatic test_round_robin();
    bit saf, slf, to;
    logic [3:0]  ea;
    logic [31:0] ed;
    run_stream(4, 4, saf, slf, to);
    total++; if (to) begin bad++; $display("FAIL rr_timeout got=%0d writes exp=8", rec_n); end
    for (int k = 0; k < 8 && k < rec_n; k++) begin
      ea = (k % 2 == 0) ? 4'(8 + k/2) : 4'(4 + k/2);
      ed = (k % 2 == 0) ? 32'(32'hB0 + k/2) : 32'(32'hA0 + k/2);
      total++; if (rec_addr[k] !== ea || rec_data[k] !== ed) begin
        bad++; $display("FAIL rr_write%0d got=%0d/%h exp=%0d/%h", k, rec_addr[k], rec_data[k], ea, ed); end
    end
    total++; if (!saf) begin bad++; $display("FAIL rr_alu_full got=%b exp=1", saf); end
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rr_drain_we got=%b exp=0", wr_en); end
  endtask

  task automatic test_backpressure();
    bit saf, slf, to;
    int ac = 0, lc = 0;
    run_stream(4, 6, saf, slf, to);
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=%0d writes exp=10", rec_n); end
    total++; if (!slf) begin bad++; $display("FAIL bp_ld_full got=%b exp=1", slf); end
    for (int k = 0; k < rec_n; k++) begin
      total++;
      if (rec_addr[k] >= 4'd8) begin
        if (rec_addr[k] !== 4'(8 + lc) || rec_data[k] !== 32'(32'hB0 + lc)) begin
          bad++; $display("FAIL bp_ld%0d got=%0d/%h exp=%0d/%h", lc, rec_addr[k], rec_data[k], 8 + lc, 32'hB0 + lc); end
        lc++;
      end else begin
        if (rec_addr[k] !== 4'(4 + ac) || rec_data[k] !== 32'(32'hA0 + ac)) begin
          bad++; $display("FAIL bp_alu%0d got=%0d/%h exp=%0d/%h", ac, rec_addr[k], rec_data[k], 4 + ac, 32'hA0 + ac); end
        ac++;
      end
    end
    total++; if (lc != 6 || ac != 4) begin bad++; $display("FAIL bp_counts got=ld%0d/alu%0d exp=ld6/alu4", lc, ac); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL bp_extra_write got=%b exp=0", wr_en); end
    end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_addr = 4'd6; alu_data = 32'h66;
    ld_valid  = 1; ld_addr  = 4'd7; ld_data  = 32'h77;
    @(negedge clk);
    alu_valid = 0; ld_valid = 0;
    rst = 1;
    #1;
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rmid_we_in_rst got=%b exp=0", wr_en); end
    total++; if ({alu_ready, ld_ready} !== 2'b00) begin bad++; $display("FAIL rmid_ready got=%b exp=00", {alu_ready, ld_ready}); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rmid_we_rst%0d got=%b exp=0", c, wr_en); end
    end
    rst = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rmid_flushed%0d got=%b exp=0", c, wr_en); end
    end
    alu_valid = 1; alu_addr = 4'd5; alu_data = 32'h55;
    @(negedge clk);
    alu_valid = 0;
    total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd5, 32'h55}) begin
      bad++; $display("FAIL rmid_r5 got=%b/%0d/%h exp=1/5/55", wr_en, wr_addr, wr_data); end
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rmid_final_idle got=%b exp=0", wr_en); end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_tie();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Writeback arbiter sitting directly upstream of the register file's single write port. It accepts writeback requests from two producers (ALU result path and load-return path), buffers each in a small per-source FIFO, and issues at most one register write per cycle using round-robin arbitration. Its outputs connect straight to the register file's write address, write data and write enable inputs.

## Interface
- `REG_WIDTH`, 32, register data width
- `ADDR_WIDTH`, 4, register address width
- `FIFO_DEPTH`, 2, entries per source FIFO; a power of two, ≥ 2
- `i_clk`  in  1  clock; all state updates on its rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_alu_valid`  in  1  ALU writeback request
- `o_alu_ready`  out  1  ALU FIFO can accept
- `i_alu_addr`  in  ADDR_WIDTH  ALU destination register
- `i_alu_data`  in  REG_WIDTH  ALU result
- `i_ld_valid`  in  1  load writeback request
- `o_ld_ready`  out  1  load FIFO can accept
- `i_ld_addr`  in  ADDR_WIDTH  load destination register
- `i_ld_data`  in  REG_WIDTH  load data
- `o_reg_addr_w`  out  ADDR_WIDTH  register file write address
- `o_reg_val_w`  out  REG_WIDTH  register file write data
- `o_write_en`  out  1  register file write enable

## Operation
- Push:
  - A source pushes when valid && ready at a rising edge.
  - `o_*_ready = !full && !i_rst`. Ready depends only on registered occupancy, never on the same-cycle pop, so there is no combinational valid→ready path.
- Per-source FIFO:
  - In-order storage, depth `FIFO_DEPTH`.
  - Count width `$clog2(FIFO_DEPTH)+1`.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- Arbitration (combinational on FIFO heads):
  - Only one FIFO non-empty: grant it.
  - Both non-empty: grant the source not granted last. The `last_grant` flop updates only when a grant occurs.
  - Neither non-empty: no grant.
- Issue:
  - `o_write_en = 1` iff a grant occurs.
  - `o_reg_addr_w` / `o_reg_val_w` = granted FIFO head.
  - When `o_write_en = 0`, both are driven to 0.
  - The granted FIFO pops at the same edge.
- Simultaneous push and pop on one FIFO:
  - Allowed when not full.
  - Count is unchanged.
  - The pushed entry lands behind the current head.
- Order and hazards:
  - Order is preserved within a source.
  - No ordering is guaranteed between sources. Upstream must not have outstanding writes to the same register from both sources.
  - Address 0 is written like any other register.

## Timing
- Reset (`i_rst` high at an edge):
  - Both FIFOs empty.
  - `last_grant` = ALU, so LOAD wins the first tie.
  - `o_write_en = 0`, `o_reg_addr_w = 0`, `o_reg_val_w = 0`.
  - `o_alu_ready = o_ld_ready = 0` while `i_rst` is high. Both return to 1 in the first cycle after reset is released.
- Reset mid-operation: all buffered entries are discarded, and no write is issued in any cycle where `i_rst` is high.
- Latency:
  - An entry pushed at edge N is at the FIFO head in cycle N+1.
  - If granted there, `o_write_en` is high in cycle N+1 and the register file captures it at edge N+2.
  - Per-source worst case with both sources saturated: one write every 2 cycles.
- Throughput: one register write per cycle total.
- Full FIFO:
  - Ready is low and no push is accepted.
  - Upstream must hold valid, addr and data stable until ready.

## Structure
- Shared package `wb_pkg`:
  - `typedef enum logic {SRC_ALU, SRC_LOAD} wb_src_e`
  - `typedef struct packed {addr, data} wb_entry_t`, parameterised via package localparams matching `REG_WIDTH` / `ADDR_WIDTH`.
- Sub-module `wb_fifo`, instantiated twice:
  - Parameterised on entry type and depth.
  - Ports: push, pop, head, full, empty.
- The top level holds the arbiter, the `last_grant` flop and output muxing only.

## Test plan
- Reset then idle: `i_rst` high for 2 cycles → `o_write_en = 0`, `o_reg_addr_w = 0`, readies 0. After release, readies = 1 and `o_write_en` stays 0 with no requests.
- Single ALU write: push addr 3, data 0xDEADBEEF at edge N → cycle N+1 shows `o_write_en = 1`, addr 3, data 0xDEADBEEF. Cycle N+2 shows `o_write_en = 0`.
- Tie after reset: both push at the same edge (ALU r1=0x11, LD r2=0x22) → LD r2 issued first, ALU r1 the next cycle.
- Round-robin saturation: both sources stream 4 entries each, back to back → grants alternate LD, ALU, LD, ALU …. Each source's writes appear in push order, and readies drop when full.
- Full/backpressure: `FIFO_DEPTH = 2`, LD streams while ALU is held busy by a competing stream → `o_ld_ready = 0` after 2 unpopped entries. Held valid data is accepted exactly once when ready returns, with no duplicates or losses.
- Reset mid-stream: assert `i_rst` with 2 entries buffered → no write issued during reset or after it. Both FIFOs are empty, and the next push of r5=0x55 issues after 1 cycle.
